// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 4-digit scanned 7-segment driver.
//   - Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
//   - Blank patterns for segments and anodes
//   - Per-frame snapshot record
//   - digit_sel(): picks digit idx from the packed word (BCD bytes or hex nibbles)
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Inputs frozen for one full frame so a digit update never tears.
  typedef struct packed {
    logic [31:0] value;
    logic        flag;
    logic        blank_en;
    logic [3:0]  dp;
  } snap_t;

  // flag = 0: digit k is the low nibble of byte k (BCD packing).
  // flag = 1: digit k is nibble k of the low 16 bits (hex).
  function automatic logic [3:0] digit_sel(input logic [31:0] value,
                                           input logic        flag,
                                           input logic [1:0]  idx);
    logic [3:0] hex_d;
    logic [3:0] bcd_d;
    case (idx)
      2'd0:    begin hex_d = value[3:0];   bcd_d = value[3:0];   end
      2'd1:    begin hex_d = value[7:4];   bcd_d = value[11:8];  end
      2'd2:    begin hex_d = value[11:8];  bcd_d = value[19:16]; end
      default: begin hex_d = value[15:12]; bcd_d = value[27:24]; end
    endcase
    return flag ? hex_d : bcd_d;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble -> active-low 7-segment pattern.
//   i_nibble : 4-bit digit value (full hex; BCD values above 9 decode as hex)
//   o_seg    : {g,f,e,d,c,b,a}, active low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      default: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode display.
//   clk, reset : system clock, synchronous active-high reset
//   value      : packed word (BCD byte-packed or raw hex, chosen by flag)
//   flag       : 0 = BCD packing, 1 = hex of value[15:0]
//   blank_en   : 1 = blank leading zeros (digit 0 always shown)
//   dp_in      : per-digit decimal point request, 1 = lit
//   an         : anode enables, active low, an[0] = rightmost digit
//   seg        : {g,f,e,d,c,b,a}, active low
//   dp         : decimal point, active low
// One digit is scanned per REFRESH_DIV cycles; inputs are snapshotted on the
// idx 3->0 wrap, and all outputs are registered (1 cycle after idx/snapshot).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned NUM_DIGITS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        flag,
  input  logic        blank_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [1:0] IDX_LAST  = 2'(NUM_DIGITS - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  snap_t         r_snap;

  logic          w_tick;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic          w_nonzero_here_or_above;
  logic          w_blank;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  assign w_tick  = (r_presc == P_LAST);
  assign w_digit = digit_sel(r_snap.value, r_snap.flag, r_idx);

  seg7_hex_decode u_dec (
    .i_nibble (w_digit),
    .o_seg    (w_seg_dec)
  );

  // A slot is a leading zero when it and every more-significant digit are 0.
  always_comb begin
    w_nonzero_here_or_above = 1'b0;
    for (int unsigned j = 0; j < 4; j++) begin
      if ((j >= 32'(r_idx)) &&
          (digit_sel(r_snap.value, r_snap.flag, 2'(j)) != 4'd0)) begin
        w_nonzero_here_or_above = 1'b1;
      end
    end
    w_blank = r_snap.blank_en && (r_idx != 2'd0) && !w_nonzero_here_or_above;
  end

  always_comb begin
    w_an  = AN_OFF;
    w_seg = SEG_BLANK;
    w_dp  = 1'b1;
    if (!w_blank) begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = w_seg_dec;
      w_dp  = ~r_snap.dp[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      an      <= AN_OFF;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        if (r_idx == IDX_LAST) begin
          r_idx  <= '0;
          r_snap <= '{value: value, flag: flag, blank_en: blank_en, dp: dp_in};
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      an  <= w_an;
      seg <= w_seg;
      dp  <= w_dp;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV = 4.
// The reference model counts edges since reset: the display state after k
// edges is slot (k/R)%4, and the frame content is whatever inputs were present
// at the last multiple of 4R edges (zero in the first frame).
module tb_seg7_scan_driver;

  localparam int unsigned R     = 4;
  localparam int unsigned FRAME = 4 * R;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = '0;
  logic        flag = 1'b0;
  logic        blank_en = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan_driver #(.REFRESH_DIV(R), .NUM_DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .flag     (flag),
    .blank_en (blank_en),
    .dp_in    (dp_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state
  int unsigned k = 0;
  logic [31:0] m_val = '0;
  logic        m_flag = 1'b0;
  logic        m_blank = 1'b0;
  logic [3:0]  m_dp = '0;

  function automatic exp_t display(input int unsigned slot);
    exp_t        e;
    int unsigned dig [4];
    bit          lit;
    for (int i = 0; i < 4; i++)
      dig[i] = m_flag ? ((m_val >> (4 * i)) & 32'hF) : ((m_val >> (8 * i)) & 32'hF);
    lit = 1'b1;
    if (m_blank && slot > 0) begin
      lit = 1'b0;
      for (int unsigned j = slot; j < 4; j++)
        if (dig[j] != 0) lit = 1'b1;
    end
    if (!lit) begin
      e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
    end else begin
      e.an  = 4'(15 - (1 << slot));
      e.seg = seg_tbl[dig[slot]];
      e.dp  = !m_dp[slot];
    end
    return e;
  endfunction

  // Model: one expected output per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset) begin
        e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
        q.push_back(e);
        k = 0; m_val = '0; m_flag = 1'b0; m_blank = 1'b0; m_dp = '0;
      end else begin
        q.push_back(display((k / R) % 4));
        k++;
        if (k % FRAME == 0) begin
          m_val = value; m_flag = flag; m_blank = blank_en; m_dp = dp_in;
        end
      end
    end
  end

  // Monitor: compares away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
          errors++;
          $display("FAIL out t=%0t k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   $time, k, an, seg, dp, e.an, e.seg, e.dp);
        end
        checks++;
        if (an !== 4'b1111 && $countones(~an) != 1) begin
          errors++;
          $display("FAIL onehot t=%0t got an=%b want at most one low", $time, an);
        end
      end
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [31:0] v, input logic f, input logic b,
                       input logic [3:0] d, input int unsigned n);
    value = v; flag = f; blank_en = b; dp_in = d;
    cycles(n);
  endtask

  initial begin
    logic [31:0] masks [4] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_0F0F, 32'h0F00_000F};
    int unsigned guard;

    // Reset 3 cycles, first frame shows zeros regardless of inputs.
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    apply(32'h01020304, 1'b0, 1'b0, 4'b0000, 2 * FRAME);
    apply(32'h00000007, 1'b0, 1'b1, 4'b0100, 2 * FRAME);
    apply(32'h00000000, 1'b0, 1'b1, 4'b0000, 2 * FRAME);
    apply(32'h0000BEEF, 1'b1, 1'b0, 4'b1001, 2 * FRAME);
    apply(32'h0A0B0C0D, 1'b0, 1'b1, 4'b1111, 2 * FRAME);

    // Mid-frame change while idx = 1.
    apply(32'h01020304, 1'b0, 1'b0, 4'b0000, 2 * FRAME);
    guard = 0;
    while (((k % FRAME) / R) != 1 && guard < FRAME) begin cycles(1); guard++; end
    apply(32'h09090909, 1'b0, 1'b0, 4'b0000, 2 * FRAME);

    // Randomized inputs, changing at arbitrary points in the frame.
    for (int i = 0; i < 40; i++) begin
      apply($urandom & masks[$urandom_range(0, 3)], 1'($urandom), 1'($urandom),
            4'($urandom), $urandom_range(1, 24));
    end

    // Reset for one cycle at idx = 2, prescaler = 2.
    apply(32'h05060708, 1'b0, 1'b0, 4'b0010, 2 * FRAME);
    guard = 0;
    while ((k % FRAME) != (2 * R + 2) && guard < FRAME) begin cycles(1); guard++; end
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(2 * FRAME + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
